rpn_stack_ctrl: RTL

Command sequencer for the RPN calculator's data stack. It accepts one stack command at a time over a valid/ready handshake and drives the synchronous stack RAM port. It keeps the top-of-stack (TOS) in a register and tracks stack depth. It executes PUSH/DROP/DUP/CLEAR and 8-bit ADD/SUB/MUL, and exposes TOS, depth and error status for display. It sits between the key/switch front end and the single-port stack RAM.

---
 rtl/rpn_stack_ctrl_if.sv | 24 ++
 rtl/rpn_stack_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_ctrl_if.sv
// Command handshake between the calculator front end and the stack controller.
// The master presents a 3-bit command plus its PUSH operand; the slave answers with ready.
interface rpn_stack_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd;
    logic [DATA_W-1:0] data_in;

    modport master (
        output cmd_valid,
        output cmd,
        output data_in,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  data_in,
        output cmd_ready
    );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// RPN data-stack sequencer: TOS held in a register, the rest of the stack lives in a
// single-port synchronous RAM. Commands that need NOS take an IDLE->FETCH->EXEC trip.
module rpn_stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    rpn_stack_ctrl_if.slave   cmd_if,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] tos,
    output logic [ADDR_W:0]   depth,
    output logic              carry,
    output logic              ovf,
    output logic              unf
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_PUSH  = 3'b001;
    localparam logic [2:0] CMD_DROP  = 3'b010;
    localparam logic [2:0] CMD_DUP   = 3'b011;
    localparam logic [2:0] CMD_ADD   = 3'b100;
    localparam logic [2:0] CMD_SUB   = 3'b101;
    localparam logic [2:0] CMD_MUL   = 3'b110;
    localparam logic [2:0] CMD_CLEAR = 3'b111;

    localparam logic [ADDR_W:0] DEPTH_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO       = (ADDR_W+1)'(2);

    // Returns {carry, result}; for SUB the top bit of the wrapped difference is the borrow.
    function automatic logic [DATA_W:0] alu(input logic [2:0]        op,
                                            input logic [DATA_W-1:0] n,
                                            input logic [DATA_W-1:0] t);
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, n} * {{DATA_W{1'b0}}, t};
        case (op)
            CMD_ADD: alu = {1'b0, n} + {1'b0, t};
            CMD_SUB: alu = {1'b0, n} - {1'b0, t};
            default: alu = {|prod[2*DATA_W-1:DATA_W], prod[DATA_W-1:0]};
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] tos_q, tos_d;
    logic [ADDR_W:0]   depth_q, depth_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              accept;
    logic [ADDR_W:0]   depth_m1;
    logic [ADDR_W:0]   depth_m2;
    logic [DATA_W:0]   alu_res;

    assign cmd_if.cmd_ready = (state_q == IDLE) && reset;
    assign accept   = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign depth_m1 = depth_q - ONE;
    assign depth_m2 = depth_q - TWO;
    assign alu_res  = alu(cmd_q, ram_rdata, tos_q);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tos_d     = tos_q;
        depth_d   = depth_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d = cmd_if.cmd;
                    case (cmd_if.cmd)
                        CMD_NOP: ;
                        CMD_PUSH: begin
                            if (depth_q == DEPTH_MAX) begin
                                ovf_d = 1'b1;
                            end else begin
                                if (depth_q != '0) begin
                                    ram_we    = 1'b1;
                                    ram_addr  = depth_m1[ADDR_W-1:0];
                                    ram_wdata = tos_q;
                                end
                                tos_d   = cmd_if.data_in;
                                depth_d = depth_q + ONE;
                            end
                        end
                        CMD_DUP: begin
                            if (depth_q == '0) begin
                                unf_d = 1'b1;
                            end else if (depth_q == DEPTH_MAX) begin
                                ovf_d = 1'b1;
                            end else begin
                                ram_we    = 1'b1;
                                ram_addr  = depth_m1[ADDR_W-1:0];
                                ram_wdata = tos_q;
                                depth_d   = depth_q + ONE;
                            end
                        end
                        CMD_DROP: begin
                            if (depth_q == '0) begin
                                unf_d = 1'b1;
                            end else if (depth_q == ONE) begin
                                depth_d = '0;
                                tos_d   = '0;
                            end else begin
                                state_d = FETCH;
                            end
                        end
                        CMD_ADD, CMD_SUB, CMD_MUL: begin
                            if (depth_q < TWO) unf_d = 1'b1;
                            else               state_d = FETCH;
                        end
                        CMD_CLEAR: begin
                            depth_d = '0;
                            tos_d   = '0;
                            carry_d = 1'b0;
                            ovf_d   = 1'b0;
                            unf_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            FETCH: begin
                // NOS address goes out now; its data arrives in EXEC.
                ram_addr = depth_m2[ADDR_W-1:0];
                state_d  = EXEC;
            end
            EXEC: begin
                state_d = IDLE;
                depth_d = depth_m1;
                if (cmd_q == CMD_DROP) tos_d = ram_rdata;
                else                   {carry_d, tos_d} = alu_res;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cmd_q   <= CMD_NOP;
            tos_q   <= '0;
            depth_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tos_q   <= tos_d;
            depth_q <= depth_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign tos   = tos_q;
    assign depth = depth_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule
